// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM stage.
// Holds FSM state type, WB control bit positions and word-address LSB.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int ADDR_LSB    = 2;

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: DEPTH x 32 word array, synchronous write, async read.
// Ports: clk, we, addr (word index), wdata, rdata.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: branch resolve, latency-configurable load/store, MEM/WB reg.
// Ports: EX/MEM inputs (MEM_*), startin reset, pc_src/pc_branch_target,
// mem_stall, registered WB_* outputs, misalign_err.
// Optional macro MEM_MISALIGN_CHECK_EN: flag and squash misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        startin,
  input  logic [1:0]  MEM_wb,
  input  logic        MEM_branch,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [31:0] MEM_branch_target,
  input  logic        MEM_zero,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_reg_data2,
  input  logic [4:0]  MEM_mux_out,
  output logic        pc_src,
  output logic [31:0] pc_branch_target,
  output logic        mem_stall,
  output logic [1:0]  WB_wb,
  output logic [31:0] WB_read_data,
  output logic [31:0] WB_alu_result,
  output logic [4:0]  WB_mux_out,
  output logic        misalign_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W =
    (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  logic             access;
  logic             misaligned;
  logic             commit;
  logic             we;
  logic             load_commit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rdata;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       wb_q, wb_d;
  logic [31:0]      rd_q, rd_d;
  logic [31:0]      alu_q, alu_d;
  logic [4:0]       dst_q, dst_d;

  assign access = MEM_mem_read | MEM_mem_write;
  assign idx    = MEM_alu_result[ADDR_LSB +: IDX_W];

  assign pc_src           = MEM_branch & MEM_zero;
  assign pc_branch_target = MEM_branch_target;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misaligned =
    access & (MEM_alu_result[ADDR_LSB-1:0] != '0);

  always_comb begin
    misalign_d = misalign_q | misaligned;
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Reset overrides everything: no stall, no commit, FSM to IDLE.
  // Misaligned accesses are squashed in one cycle, so never stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    commit    = 1'b0;
    if (startin) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            if ((MEM_LATENCY > 0) && !misaligned) begin
              mem_stall = 1'b1;
              state_d   = WAIT;
              cnt_d     = CNT_W'(MEM_LATENCY - 1);
            end else begin
              commit = 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write wins over read when both are set.
  assign we = commit & MEM_mem_write & ~misaligned;
  assign load_commit =
    commit & MEM_mem_read & ~MEM_mem_write & ~misaligned;

  data_memory #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (idx),
    .wdata (MEM_reg_data2),
    .rdata (rdata)
  );

  always_comb begin
    wb_d  = MEM_wb;
    rd_d  = load_commit ? rdata : 32'h0;
    alu_d = MEM_alu_result;
    dst_d = MEM_mux_out;
    if (misaligned) begin
      wb_d[WB_REGWRITE] = 1'b0;
    end
    if (mem_stall) begin
      wb_d  = '0;
      rd_d  = '0;
      alu_d = '0;
      dst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      wb_q  <= '0;
      rd_q  <= '0;
      alu_q <= '0;
      dst_q <= '0;
    end else begin
      wb_q  <= wb_d;
      rd_q  <= rd_d;
      alu_q <= alu_d;
      dst_q <= dst_d;
    end
  end

  assign WB_wb         = wb_q;
  assign WB_read_data  = rd_q;
  assign WB_alu_result = alu_q;
  assign WB_mux_out    = dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Reference model is a plain word array plus per-op latency rules.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        startin;
  logic [1:0]  MEM_wb;
  logic        MEM_branch;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [31:0] MEM_branch_target;
  logic        MEM_zero;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_reg_data2;
  logic [4:0]  MEM_mux_out;
  logic        pc_src;
  logic [31:0] pc_branch_target;
  logic        mem_stall;
  logic [1:0]  WB_wb;
  logic [31:0] WB_read_data;
  logic [31:0] WB_alu_result;
  logic [4:0]  WB_mux_out;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_stage #(
    .MEM_DEPTH   (DEPTH),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk               (clk),
    .startin           (startin),
    .MEM_wb            (MEM_wb),
    .MEM_branch        (MEM_branch),
    .MEM_mem_read      (MEM_mem_read),
    .MEM_mem_write     (MEM_mem_write),
    .MEM_branch_target (MEM_branch_target),
    .MEM_zero          (MEM_zero),
    .MEM_alu_result    (MEM_alu_result),
    .MEM_reg_data2     (MEM_reg_data2),
    .MEM_mux_out       (MEM_mux_out),
    .pc_src            (pc_src),
    .pc_branch_target  (pc_branch_target),
    .mem_stall         (mem_stall),
    .WB_wb             (WB_wb),
    .WB_read_data      (WB_read_data),
    .WB_alu_result     (WB_alu_result),
    .WB_mux_out        (WB_mux_out),
    .misalign_err      (misalign_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  bit          err_exp = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(
    input logic        br,
    input logic        zero,
    input logic        rd,
    input logic        wr,
    input logic [31:0] tgt,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [4:0]  dst,
    input logic [1:0]  wb
  );
    MEM_branch        = br;
    MEM_zero          = zero;
    MEM_mem_read      = rd;
    MEM_mem_write     = wr;
    MEM_branch_target = tgt;
    MEM_alu_result    = addr;
    MEM_reg_data2     = data;
    MEM_mux_out       = dst;
    MEM_wb            = wb;
  endtask

  // One instruction through the stage, checked cycle by cycle.
  task automatic run_op(
    input logic        br,
    input logic        zero,
    input logic        rd,
    input logic        wr,
    input logic [31:0] tgt,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [4:0]  dst,
    input logic [1:0]  wb,
    input string       nm
  );
    int          idx;
    int          n;
    bit          acc;
    bit          mis;
    logic [1:0]  ewb;
    logic [31:0] erd;
    logic [1:0]  lo;
    idx = int'((addr >> 2) % DEPTH);
    acc = rd | wr;
    lo  = addr[1:0];
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = acc && (lo != 2'b00);
`endif
    n   = (acc && !mis) ? LAT : 0;
    ewb = (acc && mis) ? (wb & 2'b01) : wb;
    erd = (rd && !wr && !mis) ? model[idx] : 32'h0;
    @(negedge clk);
    drive(br, zero, rd, wr, tgt, addr, data, dst, wb);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (mem_stall !== 1'(c < n) || pc_src !== (br & zero) ||
          pc_branch_target !== tgt) begin
        errors++;
        $display("FAIL %s comb c=%0d stall=%b/%b pc_src=%b/%b tgt=%h/%h",
                 nm, c, mem_stall, 1'(c < n), pc_src, br & zero,
                 pc_branch_target, tgt);
      end
      @(posedge clk);
      #1;
      if (c < n) begin
        checks++;
        if ({WB_wb, WB_read_data, WB_alu_result, WB_mux_out} !== '0) begin
          errors++;
          $display("FAIL %s bubble c=%0d wb=%b rd=%h alu=%h dst=%0d want 0",
                   nm, c, WB_wb, WB_read_data, WB_alu_result, WB_mux_out);
        end
      end
    end
    checks++;
    if (WB_wb !== ewb || WB_read_data !== erd ||
        WB_alu_result !== addr || WB_mux_out !== dst) begin
      errors++;
      $display("FAIL %s wb got %b %h %h %0d want %b %h %h %0d", nm,
               WB_wb, WB_read_data, WB_alu_result, WB_mux_out,
               ewb, erd, addr, dst);
    end
    if (wr && !mis) model[idx] = data;
    err_exp = err_exp | mis;
    checks++;
    if (misalign_err !== err_exp) begin
      errors++;
      $display("FAIL %s misalign_err got %b want %b",
               nm, misalign_err, err_exp);
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    startin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({WB_wb, WB_read_data, WB_alu_result, WB_mux_out} !== '0 ||
        mem_stall !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset wb=%b rd=%h alu=%h dst=%0d stall=%b err=%b want 0",
               WB_wb, WB_read_data, WB_alu_result, WB_mux_out,
               mem_stall, misalign_err);
    end
    @(negedge clk);
    drive(0, 0, 1, 1, 0, 32'h20, 32'h1234, 5'd3, 2'b11);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", mem_stall);
    end
    @(posedge clk);
    #1;
    startin = 1'b0;
    err_exp = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fill();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      run_op(0, 0, 0, 1, 0, 32'(i * 4), v, 5'(i), 2'b00, "fill");
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd9, 2'b00);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (mem_stall !== 1'(c < 2)) begin
        errors++;
        $display("FAIL store_stall c=%0d got %b want %b",
                 c, mem_stall, 1'(c < 2));
      end
      @(posedge clk);
      #1;
      checks++;
      if (c < 2 && (WB_wb !== 2'b00 ||
                    dut.u_dmem.mem_q[4] === 32'hDEADBEEF)) begin
        errors++;
        $display("FAIL store_early c=%0d wb=%b word4=%h want wb 0, old word",
                 c, WB_wb, dut.u_dmem.mem_q[4]);
      end else if (c == 2 && dut.u_dmem.mem_q[4] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL store_word4 got %h want deadbeef",
                 dut.u_dmem.mem_q[4]);
      end
    end
    model[4] = 32'hDEADBEEF;
  endtask

  task automatic test_load();
    run_op(0, 0, 1, 0, 0, 32'h10, 0, 5'd21, 2'b11, "load");
    checks++;
    if (WB_read_data !== 32'hDEADBEEF || WB_wb !== 2'b11) begin
      errors++;
      $display("FAIL load_const got %h %b want deadbeef 11",
               WB_read_data, WB_wb);
    end
  endtask

  task automatic test_branch();
    run_op(1, 1, 0, 0, 32'h40, 32'h5, 0, 5'd1, 2'b10, "br_taken");
    run_op(1, 0, 0, 0, 32'h40, 32'h6, 0, 5'd2, 2'b10, "br_not");
    run_op(1, 1, 1, 0, 32'h80, 32'h8, 0, 5'd4, 2'b11, "br_stall");
  endtask

  task automatic test_wrap();
    run_op(0, 0, 0, 1, 0, 32'h400, 32'h0BADF00D, 0, 0, "wrap_st");
    checks++;
    if (dut.u_dmem.mem_q[0] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL wrap_word0 got %h want 0badf00d", dut.u_dmem.mem_q[0]);
    end
    run_op(0, 0, 1, 0, 0, 32'h0, 0, 5'd5, 2'b11, "wrap_ld");
    run_op(0, 0, 1, 1, 0, 32'h8, 32'h77, 5'd6, 2'b11, "rdwr");
  endtask

  task automatic test_back_to_back();
    run_op(0, 0, 1, 0, 0, 32'h4, 0, 5'd10, 2'b11, "b2b_0");
    run_op(0, 0, 1, 0, 0, 32'hC, 0, 5'd11, 2'b11, "b2b_1");
    run_op(0, 0, 0, 0, 0, 32'h99, 0, 5'd12, 2'b10, "b2b_alu");
  endtask

  task automatic test_reset_mid();
    logic [31:0] old8;
    old8 = model[8];
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h20, ~old8, 5'd3, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rmid_stall2 got %b want 1", mem_stall);
    end
    startin = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rmid_rst_stall got %b want 0", mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({WB_wb, WB_read_data, WB_alu_result, WB_mux_out} !== '0 ||
        misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_wb wb=%b rd=%h alu=%h dst=%0d err=%b want 0",
               WB_wb, WB_read_data, WB_alu_result, WB_mux_out, misalign_err);
    end
    err_exp = 1'b0;
    @(negedge clk);
    startin = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after_stall got %b want 0", mem_stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.u_dmem.mem_q[8] !== old8) begin
      errors++;
      $display("FAIL rmid_word8 got %h want %h", dut.u_dmem.mem_q[8], old8);
    end
    run_op(0, 0, 1, 0, 0, 32'h20, 0, 5'd8, 2'b11, "rmid_ld");
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    run_op(0, 0, 0, 1, 0, 32'h11, 32'hCAFE0000, 5'd2, 2'b10, "mis_st");
    run_op(0, 0, 1, 0, 0, 32'h10, 0, 5'd3, 2'b11, "mis_chk");
    run_op(0, 0, 1, 0, 0, 32'h13, 0, 5'd4, 2'b11, "mis_ld");
  endtask
`endif

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tgt;
    logic [4:0]  dst;
    logic [1:0]  wb;
    int          k;
    for (int i = 0; i < 60; i++) begin
      r    = $urandom;
      addr = {r[31:10], 4'b0000, 4'($urandom_range(0, 15)), 2'b00};
`ifndef MEM_MISALIGN_CHECK_EN
      addr[1:0] = r[1:0];
`else
      if (r[9:7] == 3'b000) addr[1:0] = r[1:0];
`endif
      data = $urandom;
      tgt  = $urandom;
      dst  = 5'($urandom);
      wb   = 2'($urandom);
      k    = $urandom_range(0, 4);
      unique case (k)
        0: run_op(r[2], r[3], 0, 0, tgt, addr, data, dst, wb, "rnd_alu");
        1, 3: run_op(r[2], r[3], 1, 0, tgt, addr, data, dst, wb, "rnd_ld");
        2: run_op(r[2], r[3], 0, 1, tgt, addr, data, dst, wb, "rnd_st");
        default: run_op(r[2], r[3], 1, 1, tgt, addr, data, dst, wb, "rnd_rw");
      endcase
    end
  endtask

  initial begin
    startin = 1'b1;
    test_reset();
    test_fill();
    test_store();
    test_load();
    test_branch();
    test_wrap();
    test_back_to_back();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
